// File: rtl/pb_soc_bus_pkg.sv
// Shared widths, sequencer state encoding and register map for the PicoBlaze SoC register bus.
package pb_soc_bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } bus_state_t;

    localparam logic [ADDR_W-1:0] LED_OUT      = 8'h00;
    localparam logic [ADDR_W-1:0] UART_TX_DATA = 8'h03;
    localparam logic [ADDR_W-1:0] UART_STATUS  = 8'h04;
    localparam logic [ADDR_W-1:0] UART_RX_DATA = 8'h06;
    localparam logic [ADDR_W-1:0] SIM_STATUS   = 8'hFF;

endpackage

// File: rtl/pb_soc_rr_arbiter.sv
// Two-way grant selection: a lone requester wins; ties go to the master that did not win last
// (round-robin) or always to master 0 (fixed priority).
module pb_soc_rr_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic req0,
    input  logic req1,
    input  logic owner,
    output logic winner
);

    always_comb begin
        winner = 1'b0;
        if (req0 && req1) begin
            winner = RR_ENABLE ? ~owner : 1'b0;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/pb_soc_bus_arbiter.sv
// Two-master register-bus arbiter: each grant becomes exactly one rd/wr strobe followed by a
// registered acknowledge carrying the read data.
//
// state | meaning
// IDLE  | waiting for a request; winner's address/data/direction latched on exit
// BUS   | single-cycle rd_o/wr_o strobe, read data captured for the winner
// ACK   | single-cycle ack to the winner, requests ignored
module pb_soc_bus_arbiter
    import pb_soc_bus_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              rd_o,
    output logic              wr_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              busy_o,
    output logic              owner_o
);

    bus_state_t state;
    logic       we_q;
    logic       winner;

    pb_soc_rr_arbiter #(
        .RR_ENABLE (RR_ENABLE)
    ) u_arb (
        .req0   (m0_req_i),
        .req1   (m1_req_i),
        .owner  (owner_o),
        .winner (winner)
    );

    // owner_o resets to 1 so the first tie goes to master 0
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            addr_o     <= '0;
            data_o     <= '0;
            rd_o       <= 1'b0;
            wr_o       <= 1'b0;
            we_q       <= 1'b0;
            owner_o    <= 1'b1;
            busy_o     <= 1'b0;
            m0_ack_o   <= 1'b0;
            m1_ack_o   <= 1'b0;
            m0_rdata_o <= '0;
            m1_rdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_req_i || m1_req_i) begin
                        state   <= BUS;
                        busy_o  <= 1'b1;
                        owner_o <= winner;
                        if (winner) begin
                            addr_o <= m1_addr_i;
                            data_o <= m1_wdata_i;
                            we_q   <= m1_we_i;
                            rd_o   <= ~m1_we_i;
                            wr_o   <= m1_we_i;
                        end else begin
                            addr_o <= m0_addr_i;
                            data_o <= m0_wdata_i;
                            we_q   <= m0_we_i;
                            rd_o   <= ~m0_we_i;
                            wr_o   <= m0_we_i;
                        end
                    end
                end
                BUS: begin
                    state <= ACK;
                    rd_o  <= 1'b0;
                    wr_o  <= 1'b0;
                    if (owner_o) begin
                        m1_rdata_o <= we_q ? '0 : data_i;
                        m1_ack_o   <= 1'b1;
                    end else begin
                        m0_rdata_o <= we_q ? '0 : data_i;
                        m0_ack_o   <= 1'b1;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    busy_o   <= 1'b0;
                    m0_ack_o <= 1'b0;
                    m1_ack_o <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
